// File: rtl/pdm_pkg.sv
// Shared types and helpers for the stereo PDM CIC decimator.
package pdm_pkg;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } channel_e;

    // Accumulator width needed for a sinc^order filter decimating by rate.
    function automatic int unsigned cic_acc_w(input int unsigned order, input int unsigned rate);
        return order * $clog2(rate) + 2;
    endfunction

    // Clamp a signed value into the signed range of a w-bit word.
    function automatic logic [31:0] sat_trunc(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi[31:0];
        end else if (x < lo) begin
            return lo[31:0];
        end
        return x[31:0];
    endfunction

endpackage

// File: rtl/pdm_cic_decim_cic_channel.sv
// One channel of the CIC decimator: N integrators, N combs and the output scaler.
module cic_channel
    import pdm_pkg::*;
#(
    parameter int unsigned ORDER    = 3,
    parameter int unsigned DEC_RATE = 64,
    parameter int unsigned OUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic                    sample_bit,
    input  logic                    frame_end,
    output logic signed [OUT_W-1:0] pcm,
    output logic                    pcm_valid
);

    localparam int unsigned ACC_W = cic_acc_w(ORDER, DEC_RATE);
    localparam int unsigned SHIFT = ACC_W - 1 - OUT_W;

    logic signed [ACC_W-1:0] integ     [ORDER];
    logic signed [ACC_W-1:0] integ_nxt [ORDER];
    logic signed [ACC_W-1:0] comb_dly  [ORDER];
    logic signed [ACC_W-1:0] comb_y    [ORDER];
    logic signed [ACC_W-1:0] x_in;
    logic signed [ACC_W-1:0] scaled;
    logic signed [OUT_W-1:0] pcm_nxt;

    // Integrator cascade uses each stage's freshly updated value so the chain
    // behaves as a pure 1/(1-z^-1)^N with no extra pipeline delay.
    always_comb begin
        x_in         = sample_bit ? ACC_W'(1) : '1;
        integ_nxt[0] = integ[0] + x_in;
        for (int unsigned i = 1; i < ORDER; i++) begin
            integ_nxt[i] = integ[i] + integ_nxt[i-1];
        end
    end

    // Comb cascade and scaling, evaluated from the integrator state at frame end.
    always_comb begin
        comb_y[0] = integ[ORDER-1] - comb_dly[0];
        for (int unsigned i = 1; i < ORDER; i++) begin
            comb_y[i] = comb_y[i-1] - comb_dly[i];
        end
        scaled  = comb_y[ORDER-1] >>> SHIFT;
        pcm_nxt = OUT_W'(sat_trunc({{(64-ACC_W){scaled[ACC_W-1]}}, scaled}, OUT_W));
    end

    // Filter state: integrators step on captures, combs step once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ORDER; i++) begin
                integ[i]    <= '0;
                comb_dly[i] <= '0;
            end
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i < ORDER; i++) begin
                integ[i]    <= '0;
                comb_dly[i] <= '0;
            end
            pcm_valid <= 1'b0;
        end else begin
            if (sample_en) begin
                for (int unsigned i = 0; i < ORDER; i++) begin
                    integ[i] <= integ_nxt[i];
                end
            end
            if (frame_end) begin
                comb_dly[0] <= integ[ORDER-1];
                for (int unsigned i = 1; i < ORDER; i++) begin
                    comb_dly[i] <= comb_y[i-1];
                end
                pcm <= pcm_nxt;
            end
            pcm_valid <= frame_end;
        end
    end

endmodule

// File: rtl/pdm_cic_decim.sv
// Stereo PDM-to-PCM decimator: PDM clock generation, L/R demux, two CIC
// channels, warm-up suppression and valid/ready output with overrun flag.
module pdm_cic_decim
    import pdm_pkg::*;
#(
    parameter int unsigned ORDER    = 3,
    parameter int unsigned DEC_RATE = 64,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                    mclk1,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic                    pdm_clk,
    input  logic                    mdata1,
    output logic signed [OUT_W-1:0] data_l,
    output logic signed [OUT_W-1:0] data_r,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned PH_W  = $clog2(CLK_DIV);
    localparam int unsigned PER_W = $clog2(DEC_RATE);
    localparam int unsigned WU_W  = $clog2(ORDER + 1);

    logic [PH_W-1:0]         phase;
    logic [PH_W-1:0]         phase_nxt;
    logic [PER_W-1:0]        period;
    logic [WU_W-1:0]         warm;
    logic [1:0]              cap;
    logic                    frame_end;
    logic signed [OUT_W-1:0] pcm [2];
    logic [1:0]              pcm_valid;
    logic                    frame_done;
    logic                    new_pair;
    logic                    ov_set;

    // Capture strobes at the last cycle of the high and low pdm_clk phases.
    always_comb begin
        cap         = '0;
        cap[CH_L]   = enable && (phase == PH_W'(HALF - 1));
        cap[CH_R]   = enable && (phase == PH_W'(CLK_DIV - 1));
        phase_nxt   = (phase == PH_W'(CLK_DIV - 1)) ? '0 : phase + 1'b1;
        frame_done  = pcm_valid[CH_L] & pcm_valid[CH_R];
        new_pair    = frame_done && (warm == WU_W'(ORDER));
        ov_set      = enable && new_pair && data_valid && !data_ready;
    end

    // Clock divider; pdm_clk is registered against the phase it will show.
    always_ff @(posedge mclk1 or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            pdm_clk <= 1'b0;
        end else if (!enable) begin
            phase   <= '0;
            pdm_clk <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            pdm_clk <= (phase_nxt < PH_W'(HALF));
        end
    end

    // Period counter over right captures; flags the frame end one cycle later.
    always_ff @(posedge mclk1 or negedge reset_n) begin
        if (!reset_n) begin
            period    <= '0;
            frame_end <= 1'b0;
        end else if (!enable) begin
            period    <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= cap[CH_R] && (period == PER_W'(DEC_RATE - 1));
            if (cap[CH_R]) begin
                period <= (period == PER_W'(DEC_RATE - 1)) ? '0 : period + 1'b1;
            end
        end
    end

    cic_channel #(
        .ORDER    (ORDER),
        .DEC_RATE (DEC_RATE),
        .OUT_W    (OUT_W)
    ) u_cic_l (
        .clk        (mclk1),
        .rst_n      (reset_n),
        .clear      (!enable),
        .sample_en  (cap[CH_L]),
        .sample_bit (mdata1),
        .frame_end  (frame_end),
        .pcm        (pcm[CH_L]),
        .pcm_valid  (pcm_valid[CH_L])
    );

    cic_channel #(
        .ORDER    (ORDER),
        .DEC_RATE (DEC_RATE),
        .OUT_W    (OUT_W)
    ) u_cic_r (
        .clk        (mclk1),
        .rst_n      (reset_n),
        .clear      (!enable),
        .sample_en  (cap[CH_R]),
        .sample_bit (mdata1),
        .frame_end  (frame_end),
        .pcm        (pcm[CH_R]),
        .pcm_valid  (pcm_valid[CH_R])
    );

    // Warm-up frame count and the output register with valid/ready handshake.
    always_ff @(posedge mclk1 or negedge reset_n) begin
        if (!reset_n) begin
            warm       <= '0;
            data_l     <= '0;
            data_r     <= '0;
            data_valid <= 1'b0;
        end else if (!enable) begin
            warm       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (frame_done && (warm != WU_W'(ORDER))) begin
                warm <= warm + 1'b1;
            end
            if (new_pair) begin
                data_l     <= pcm[CH_L];
                data_r     <= pcm[CH_R];
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    // Sticky overrun; a coincident set beats the clear.
    always_ff @(posedge mclk1 or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (ov_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Self-checking bench for pdm_cic_decim: the CIC is modelled as its equivalent
// FIR (boxcar of length R convolved ORDER times) applied to the captured bits.
module tb_pdm_cic_decim;

    localparam int ORDER   = 3;
    localparam int R       = 64;
    localparam int OUT_W   = 16;
    localparam int CLK_DIV = 4;
    localparam int HALF    = CLK_DIV / 2;
    localparam int ACC_W   = ORDER * $clog2(R) + 2;
    localparam int SHIFT   = ACC_W - 1 - OUT_W;
    localparam int HLEN    = ORDER * (R - 1) + 1;
    localparam int FRAME   = R * CLK_DIV;

    logic mclk1 = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic mdata1 = 1'b0;
    logic data_ready = 1'b0;
    logic overrun_clr = 1'b0;
    logic pdm_clk;
    logic signed [15:0] data_l;
    logic signed [15:0] data_r;
    logic data_valid;
    logic overrun;

    always #5 mclk1 = ~mclk1;

    pdm_cic_decim #(
        .ORDER    (ORDER),
        .DEC_RATE (R),
        .OUT_W    (OUT_W),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .mclk1       (mclk1),
        .reset_n     (reset_n),
        .enable      (enable),
        .pdm_clk     (pdm_clk),
        .mdata1      (mdata1),
        .data_l      (data_l),
        .data_r      (data_r),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int h [HLEN];
    int hist_l [$];
    int hist_r [$];
    int ph, per, warm, due;
    logic signed [15:0] pend_l, pend_r, exp_l, exp_r;
    logic exp_valid, exp_ov, exp_pclk;

    // Stimulus state
    int mode = 0;
    logic alt = 1'b1;
    logic rnd_hs = 1'b0;

    function automatic logic signed [15:0] ref_out(input int q[$]);
        longint acc = 0;
        int n = q.size();
        for (int k = 0; k < HLEN && k < n; k++) acc += longint'(h[k]) * q[n-1-k];
        acc = acc >>> SHIFT;
        if (acc > 32767) return 16'sh7FFF;
        if (acc < -32768) return 16'sh8000;
        return 16'(acc);
    endfunction

    task automatic model_reset();
        ph = 0; per = 0; warm = 0; due = 0;
        hist_l.delete(); hist_r.delete();
        exp_l = '0; exp_r = '0; exp_valid = 1'b0; exp_ov = 1'b0; exp_pclk = 1'b0;
    endtask

    task automatic model_edge();
        logic ov_set = 1'b0;
        logic arrival = 1'b0;
        if (!enable) begin
            ph = 0; per = 0; warm = 0; due = 0;
            hist_l.delete(); hist_r.delete();
            exp_valid = 1'b0; exp_pclk = 1'b0;
        end else begin
            if (due > 0) begin
                due--;
                arrival = (due == 0);
            end
            if (arrival && warm < ORDER) begin
                warm++;
                arrival = 1'b0;
            end
            if (arrival) begin
                ov_set = exp_valid && !data_ready;
                exp_l = pend_l; exp_r = pend_r; exp_valid = 1'b1;
            end else if (exp_valid && data_ready) begin
                exp_valid = 1'b0;
            end
            if (ph == HALF - 1) begin
                hist_l.push_back(mdata1 ? 1 : -1);
                if (hist_l.size() > HLEN) void'(hist_l.pop_front());
            end
            if (ph == CLK_DIV - 1) begin
                hist_r.push_back(mdata1 ? 1 : -1);
                if (hist_r.size() > HLEN) void'(hist_r.pop_front());
                per++;
                if (per == R) begin
                    per = 0;
                    pend_l = ref_out(hist_l);
                    pend_r = ref_out(hist_r);
                    due = 2;
                end
            end
            ph = (ph + 1) % CLK_DIV;
            exp_pclk = (ph < HALF);
        end
        if (ov_set) exp_ov = 1'b1;
        else if (overrun_clr) exp_ov = 1'b0;
    endtask

    task automatic cycle();
        logic lb, rb;
        case (mode)
            0: begin lb = 1'b1; rb = 1'b1; end
            1: begin lb = 1'b0; rb = 1'b0; end
            2: begin lb = 1'b1; rb = 1'b0; end
            3: begin lb = alt;  rb = 1'b1; end
            default: begin lb = 1'($urandom); rb = 1'($urandom); end
        endcase
        if (enable && reset_n && ph == HALF - 1) begin
            mdata1 = lb;
            if (mode == 3) alt = ~alt;
        end else if (enable && reset_n && ph == CLK_DIV - 1) begin
            mdata1 = rb;
        end else begin
            mdata1 = 1'($urandom);
        end
        if (rnd_hs) begin
            data_ready  = ($urandom % 4) != 0;
            overrun_clr = ($urandom % 16) == 0;
        end
        @(posedge mclk1);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        check("data_valid", 16'(data_valid), 16'(exp_valid));
        check("overrun", 16'(overrun), 16'(exp_ov));
        check("pdm_clk", 16'(pdm_clk), 16'(exp_pclk));
        check("data_l", data_l, exp_l);
        check("data_r", data_r, exp_r);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!data_valid && n < 3000);
    endtask

    int n;
    int highs;

    initial begin
        // Build the equivalent FIR of the sinc^ORDER decimator.
        begin
            int t [HLEN];
            for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
            for (int s = 0; s < ORDER; s++) begin
                for (int i = 0; i < HLEN; i++) begin
                    t[i] = 0;
                    for (int j = 0; j < R; j++) if (i - j >= 0) t[i] += h[i-j];
                end
                h = t;
            end
        end
        model_reset();

        // Reset state
        run(3);
        check("rst_data_l", data_l, 16'h0000);
        check("rst_valid", 16'(data_valid), 16'h0000);
        check("rst_pdm_clk", 16'(pdm_clk), 16'h0000);

        // Case 1: constant 1, first output after the 4th frame, then every frame
        reset_n = 1'b1; enable = 1'b1; data_ready = 1'b1; mode = 0;
        wait_valid(n);
        check("c1_latency", 16'(n), 16'(4 * FRAME + 2));
        check("c1_l", data_l, 16'h7FFF);
        check("c1_r", data_r, 16'h7FFF);
        wait_valid(n);
        check("c1_period", 16'(n), 16'(FRAME));

        // Case 2: enable dropped for 10 cycles, then constant 0 with fresh warm-up
        enable = 1'b0;
        run(10);
        check("dis_keep_l", data_l, 16'h7FFF);
        check("dis_valid", 16'(data_valid), 16'h0000);
        enable = 1'b1; mode = 1;
        wait_valid(n);
        check("c2_latency", 16'(n), 16'(4 * FRAME + 2));
        check("c2_l", data_l, 16'h8000);
        check("c2_r", data_r, 16'h8000);

        // Case 3: left 1 / right 0, and pdm_clk duty
        mode = 2;
        run(4 * FRAME);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            highs += int'(pdm_clk);
        end
        check("c3_pdm_duty", 16'(highs), 16'd4);
        wait_valid(n);
        check("c3_l", data_l, 16'h7FFF);
        check("c3_r", data_r, 16'h8000);

        // Case 4: left alternates per period, right constant 1
        mode = 3;
        run(4 * FRAME);
        wait_valid(n);
        check("c4_l", data_l, 16'h0000);
        check("c4_r", data_r, 16'h7FFF);

        // Case 5: consumer stalls for three frames
        cycle();
        data_ready = 1'b0; mode = 0;
        wait_valid(n);
        run(FRAME);
        check("c5_overrun", 16'(overrun), 16'h0001);
        check("c5_valid", 16'(data_valid), 16'h0001);
        run(FRAME);
        check("c5_latest_l", data_l, 16'h7FFF);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("c5_ov_clr", 16'(overrun), 16'h0000);
        data_ready = 1'b1;
        cycle();
        check("c5_accept", 16'(data_valid), 16'h0000);

        // Case 6: asynchronous reset mid-frame
        run(FRAME + FRAME / 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_l", data_l, 16'h0000);
        check("arst_r", data_r, 16'h0000);
        check("arst_valid", 16'(data_valid), 16'h0000);
        check("arst_pdm_clk", 16'(pdm_clk), 16'h0000);
        model_reset();
        run(3);
        reset_n = 1'b1;
        wait_valid(n);
        check("c6_latency", 16'(n), 16'(4 * FRAME + 2));
        check("c6_l", data_l, 16'h7FFF);
        check("c6_r", data_r, 16'h7FFF);

        // Case 7: random data, handshake and one random enable drop
        mode = 4; rnd_hs = 1'b1;
        run(6 * FRAME);
        enable = 1'b0;
        run($urandom_range(1, 20));
        enable = 1'b1;
        run(6 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
